// File: rtl/bwt_pkg.sv
// Shared types for the BWT engine: sorter, emitter and inverse stage.
package bwt_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT,
        FIN
    } emit_state_t;

    localparam byte_t PRIMARY_NONE = 8'hFF;

endpackage

// File: rtl/bwt_char_sel.sv
// Picks the BWT byte for one suffix-array entry: S[(SA-1) mod N], or 0 when SA is out of range.
module bwt_char_sel
    import bwt_pkg::*;
#(
    parameter int STRING_LEN = 8
) (
    input  byte_t                       sa_i,
    input  logic [STRING_LEN-1:0][7:0]  str_i,
    input  byte_t                       n_i,
    output byte_t                       char_o,
    output logic                        range_err_o
);

    byte_t idx;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        idx         = (sa_i == 8'd0) ? n_i - 8'd1 : sa_i - 8'd1;
        range_err_o = (sa_i >= n_i);
        char_o      = 8'h00;
        for (int k = 0; k < STRING_LEN; k++) begin
            if (!range_err_o && idx == byte_t'(k)) begin
                char_o = str_i[k];
            end
        end
    end

endmodule

// File: rtl/bwt_emit.sv
// Streams L[i] = S[(SA[i]-1) mod N] from a snapshot of the string and suffix array,
// and reports the primary index (row where SA[i]==0).
module bwt_emit
    import bwt_pkg::*;
#(
    parameter int STRING_LEN = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [STRING_LEN-1:0][7:0]  input_string,
    input  logic [STRING_LEN-1:0][7:0]  suffixes_in,
    input  logic                        start,
    output logic                        busy,
    output byte_t                       bwt_out,
    output logic                        bwt_valid,
    input  logic                        bwt_ready,
    output logic                        bwt_last,
    output byte_t                       primary_idx,
    output logic                        primary_valid,
    output logic                        err,
    output logic                        done
);

    localparam byte_t N_LEN  = byte_t'(STRING_LEN);
    localparam byte_t N_LAST = byte_t'(STRING_LEN - 1);

    emit_state_t state_q, state_d;
    byte_t       row_q, row_d;
    byte_t       bwt_q, bwt_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    byte_t       pidx_q, pidx_d;
    logic        pvalid_q, pvalid_d;
    logic        err_q, err_d;
    logic        found_q, found_d;

    logic [STRING_LEN-1:0][7:0] str_q;
    logic [STRING_LEN-1:0][7:0] sa_q;

    byte_t sel_row;
    byte_t sel_sa;
    byte_t sel_char;
    logic  sel_range_err;
    logic  load_row;
    logic  capture;

    assign capture = (state_q == IDLE) && start;

    // LOAD fetches row 0; EMIT prefetches the row after the one being handed off.
    always_comb begin
        sel_row = (state_q == LOAD) ? row_q : row_q + 8'd1;
        sel_sa  = 8'h00;
        for (int k = 0; k < STRING_LEN; k++) begin
            if (sel_row == byte_t'(k)) begin
                sel_sa = sa_q[k];
            end
        end
    end

    bwt_char_sel #(
        .STRING_LEN (STRING_LEN)
    ) u_char_sel (
        .sa_i        (sel_sa),
        .str_i       (str_q),
        .n_i         (N_LEN),
        .char_o      (sel_char),
        .range_err_o (sel_range_err)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        bwt_d    = bwt_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pidx_d   = pidx_q;
        pvalid_d = pvalid_q;
        err_d    = err_q;
        found_d  = found_q;
        load_row = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    row_d    = 8'd0;
                    err_d    = 1'b0;
                    pvalid_d = 1'b0;
                    found_d  = 1'b0;
                end
            end
            LOAD: begin
                load_row = 1'b1;
                busy_d   = 1'b1;
                state_d  = EMIT;
            end
            EMIT: begin
                if (valid_q && bwt_ready) begin
                    if (row_q == N_LAST) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        row_d    = row_q + 8'd1;
                        load_row = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                pvalid_d = 1'b1;
                if (!found_q) begin
                    err_d  = 1'b1;
                    pidx_d = PRIMARY_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_row) begin
            bwt_d   = sel_char;
            valid_d = 1'b1;
            last_d  = (sel_row == N_LAST);
            if (sel_range_err) begin
                err_d = 1'b1;
            end
            // First zero wins the primary index; any later zero is a malformed array.
            if (sel_sa == 8'd0) begin
                if (found_q) begin
                    err_d = 1'b1;
                end else begin
                    found_d = 1'b1;
                    pidx_d  = sel_row;
                end
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= 8'd0;
            bwt_q    <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pidx_q   <= 8'h00;
            pvalid_q <= 1'b0;
            err_q    <= 1'b0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            bwt_q    <= bwt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pidx_q   <= pidx_d;
            pvalid_q <= pvalid_d;
            err_q    <= err_d;
            found_q  <= found_d;
        end
    end

    // NOTE: the snapshot is pure datapath; it is only read after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            str_q <= input_string;
            sa_q  <= suffixes_in;
        end
    end

    assign busy          = busy_q;
    assign bwt_out       = bwt_q;
    assign bwt_valid     = valid_q;
    assign bwt_last      = last_q;
    assign primary_idx   = pidx_q;
    assign primary_valid = pvalid_q;
    assign err           = err_q;
    assign done          = done_q;

endmodule

// File: tb/tb_bwt_emit.sv
// Scoreboard bench for bwt_emit: expected bytes are queued at start and popped on each handshake.
module tb_bwt_emit;
    import bwt_pkg::*;

    localparam int N = 8;

    typedef logic [N-1:0][7:0] arr_t;
    typedef int sa_list_t[N];
    typedef struct {
        byte_t data;
        logic  last;
    } exp_byte_t;

    logic  clk = 1'b0;
    logic  rst_n;
    arr_t  input_string;
    arr_t  suffixes_in;
    logic  start;
    logic  busy;
    byte_t bwt_out;
    logic  bwt_valid;
    logic  bwt_ready;
    logic  bwt_last;
    byte_t primary_idx;
    logic  primary_valid;
    logic  err;
    logic  done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;

    exp_byte_t exp_q[$];
    byte_t     exp_pidx;
    logic      exp_err;

    bwt_emit #(.STRING_LEN(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_string  (input_string),
        .suffixes_in   (suffixes_in),
        .start         (start),
        .busy          (busy),
        .bwt_out       (bwt_out),
        .bwt_valid     (bwt_valid),
        .bwt_ready     (bwt_ready),
        .bwt_last      (bwt_last),
        .primary_idx   (primary_idx),
        .primary_valid (primary_valid),
        .err           (err),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic arr_t str_arr(input logic [8*N-1:0] lit);
        arr_t r;
        for (int k = 0; k < N; k++) r[k] = lit[8*(N-1-k) +: 8];
        return r;
    endfunction

    function automatic arr_t mk_sa(input sa_list_t v);
        arr_t r;
        for (int k = 0; k < N; k++) r[k] = byte_t'(v[k]);
        return r;
    endfunction

    // Reference model: L[i] = S[(SA[i]-1) mod N], 0 for out-of-range entries.
    task automatic build_expected(input arr_t s, input arr_t sa);
        logic found;
        exp_byte_t e;
        int idx;
        found    = 1'b0;
        exp_err  = 1'b0;
        exp_pidx = 8'h00;
        for (int i = 0; i < N; i++) begin
            e.last = (i == N - 1);
            if (int'(sa[i]) >= N) begin
                e.data  = 8'h00;
                exp_err = 1'b1;
            end else begin
                idx    = (int'(sa[i]) + N - 1) % N;
                e.data = s[idx];
            end
            if (sa[i] == 8'd0) begin
                if (found) exp_err = 1'b1;
                else begin
                    found    = 1'b1;
                    exp_pidx = byte_t'(i);
                end
            end
            exp_q.push_back(e);
        end
        if (!found) begin
            exp_err  = 1'b1;
            exp_pidx = PRIMARY_NONE;
        end
    endtask

    task automatic start_frame(input arr_t s, input arr_t sa);
        @(posedge clk); #1;
        input_string = s;
        suffixes_in  = sa;
        build_expected(s, sa);
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        t_start = cyc;
    endtask

    // Consumes one frame; optional stall after stall_at bytes and a stray start after poke_at bytes.
    task automatic drain(input int stall_at, input int stall_len, input int poke_at,
                         output int bytes_seen, output int done_cyc);
        int stall_left;
        bit got_done;
        bit poked;
        exp_byte_t e;
        stall_left = 0;
        got_done   = 1'b0;
        poked      = 1'b0;
        bytes_seen = 0;
        done_cyc   = -1;
        for (int c = 0; c < 200 && !got_done; c++) begin
            @(negedge clk);
            if (bwt_valid && bwt_ready) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got byte %h, expected no further bytes", bwt_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bwt_out !== e.data || bwt_last !== e.last || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stream_byte%0d: got %h last=%b busy=%b, expected %h last=%b busy=1",
                                 bytes_seen, bwt_out, bwt_last, busy, e.data, e.last);
                    end
                end
                bytes_seen++;
                if (bytes_seen == stall_at) stall_left = stall_len;
            end else if (bwt_valid && !bwt_ready) begin
                n_assert++;
                if (exp_q.size() == 0 || bwt_out !== exp_q[0].data || bwt_last !== exp_q[0].last) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h last=%b, expected held byte %h",
                             bwt_out, bwt_last, (exp_q.size() == 0) ? 8'h00 : exp_q[0].data);
                end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                done_cyc = cyc;
                n_assert++;
                if (bytes_seen != N || bwt_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_early: got %0d bytes valid=%b at done, expected %0d bytes valid=0",
                             bytes_seen, bwt_valid, N);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (poke_at >= 0 && bytes_seen == poke_at && !poked) begin
                poked        = 1'b1;
                start        = 1'b1;
                input_string = ~input_string;
                suffixes_in  = mk_sa('{0, 0, 0, 0, 0, 0, 0, 0});
            end
            if (stall_left > 0) begin
                bwt_ready = 1'b0;
                stall_left--;
            end else begin
                bwt_ready = 1'b1;
            end
        end
        start     = 1'b0;
        bwt_ready = 1'b1;
        if (!got_done) begin
            n_assert++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 200 cycles, expected a done pulse");
        end
    endtask

    task automatic check_result(input string name);
        n_assert++;
        if (primary_idx !== exp_pidx || err !== exp_err || primary_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_result: got pidx=%h err=%b pvalid=%b, expected pidx=%h err=%b pvalid=1",
                     name, primary_idx, err, primary_valid, exp_pidx, exp_err);
        end
        @(negedge clk);
        n_assert++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_width: got done=%b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_assert++;
        if ({busy, bwt_out, bwt_valid, bwt_last, primary_idx, primary_valid, err, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_in: got busy=%b out=%h valid=%b last=%b pidx=%h pv=%b err=%b done=%b, expected all 0",
                     busy, bwt_out, bwt_valid, bwt_last, primary_idx, primary_valid, err, done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || bwt_valid !== 1'b0 || done !== 1'b0 || bwt_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b valid=%b done=%b out=%h, expected 0 0 0 00",
                     busy, bwt_valid, done, bwt_out);
        end
    endtask

    task automatic test_basic();
        int nb, dc;
        start_frame(str_arr("aaaaaaa$"), mk_sa('{7, 6, 5, 4, 3, 2, 1, 0}));
        n_assert++;
        if (busy !== 1'b0 || bwt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: got busy=%b valid=%b right after start edge, expected 0 0", busy, bwt_valid);
        end
        drain(-1, 0, -1, nb, dc);
        n_assert++;
        if (dc - t_start != N + 2) begin
            n_fail++;
            $display("FAIL basic_done_time: got done %0d cycles after start, expected %0d", dc - t_start, N + 2);
        end
        check_result("basic");
    endtask

    task automatic test_mixed();
        int nb, dc;
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 2, 1, 0, 4, 5, 6}));
        drain(-1, 0, -1, nb, dc);
        check_result("mixed");
    endtask

    task automatic test_backpressure();
        int nb, dc;
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 2, 1, 0, 4, 5, 6}));
        drain(1, 3, -1, nb, dc);
        n_assert++;
        if (dc - t_start != N + 5) begin
            n_fail++;
            $display("FAIL bp_done_time: got done %0d cycles after start, expected %0d", dc - t_start, N + 5);
        end
        check_result("bp");
    endtask

    task automatic test_range_err();
        int nb, dc;
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 2, 9, 0, 4, 5, 6}));
        drain(-1, 0, -1, nb, dc);
        check_result("range");
        repeat (4) @(negedge clk);
        n_assert++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_sticky: got err=%b while idle, expected 1", err);
        end
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 2, 1, 0, 4, 5, 6}));
        n_assert++;
        if (err !== 1'b0 || primary_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL range_clear: got err=%b pvalid=%b after start, expected 0 0", err, primary_valid);
        end
        drain(-1, 0, -1, nb, dc);
        check_result("range_next");
    endtask

    task automatic test_zero_entries();
        int nb, dc;
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 2, 1, 1, 4, 5, 6}));
        drain(-1, 0, -1, nb, dc);
        check_result("nozero");
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 0, 1, 0, 4, 5, 6}));
        drain(-1, 0, -1, nb, dc);
        check_result("twozero");
    endtask

    task automatic test_start_ignored();
        int nb, dc;
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 2, 1, 0, 4, 5, 6}));
        drain(-1, 0, 3, nb, dc);
        check_result("ignore");
        repeat (3) @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || bwt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_restart: got busy=%b valid=%b after frame, expected 0 0", busy, bwt_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int got;
        start_frame(str_arr("dcbaxyz$"), mk_sa('{7, 3, 2, 1, 0, 4, 5, 6}));
        got = 0;
        for (int c = 0; c < 50 && got < 4; c++) begin
            @(negedge clk);
            if (bwt_valid && bwt_ready) got++;
        end
        @(posedge clk); #1;
        n_assert++;
        if (got != 4 || bwt_valid !== 1'b1 || bwt_out !== 8'h24) begin
            n_fail++;
            $display("FAIL abort_setup: got %0d bytes, valid=%b out=%h, expected 4 bytes and byte 4 = 24",
                     got, bwt_valid, bwt_out);
        end
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({busy, bwt_out, bwt_valid, bwt_last, primary_idx, primary_valid, err, done} !== '0) begin
            n_fail++;
            $display("FAIL abort_async: got busy=%b out=%h valid=%b last=%b pidx=%h pv=%b err=%b done=%b, expected all 0",
                     busy, bwt_out, bwt_valid, bwt_last, primary_idx, primary_valid, err, done);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || bwt_valid !== 1'b0) got++;
        end
        n_assert++;
        if (got != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d cycles with done or valid after abort, expected 0", got);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bwt_ready    = 1'b1;
        input_string = '0;
        suffixes_in  = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_mixed();
        test_backpressure();
        test_range_err();
        test_zero_entries();
        test_start_ignored();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
